// File: rtl/clkdiv_ctrl.sv
// Run-time integer clock divider controller with glitch-free ratio changes and stop.
// Latency: ratio/stop take effect at the next output-period wrap; tick/cfg_err are registered.
// Backpressure: cfg_ready drops while a ratio is pending and returns at the wrap that applies it.
// Optional: define CLKDIV_CTRL_ODD50_EN for a negedge stage giving 50% duty on odd ratios.
module clkdiv_ctrl #(
  parameter int WIDTH       = 8,
  parameter int DEFAULT_DIV = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             cfg_valid,
  input  logic [WIDTH-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic [WIDTH-1:0] div_act,
  output logic             running,
  output logic             tick,
  output logic             clkout
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PEND = 2'd2} state_t;

  localparam logic [WIDTH-1:0] DIV_RST = WIDTH'(DEFAULT_DIV);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] cnt, cnt_nxt, div_nxt, pend_div;
  logic             hs, cfg_zero, take, wrap;
  logic             clk_p, gate_d, gate_q, wave;

  assign hs       = cfg_valid & cfg_ready;
  assign cfg_zero = (cfg_div == '0);
  assign take     = hs & ~cfg_zero;
  // cnt < div_act always holds, so equality is enough to find the last cycle
  assign wrap     = (cnt == div_act - ONE);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state: stops and ratio swaps are only honoured on the wrap edge
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (en) state_nxt = RUN;
      RUN: begin
        if (wrap && !en) state_nxt = IDLE;
        else if (take)   state_nxt = PEND;
      end
      PEND:    if (wrap) state_nxt = en ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from state; the N=1 gate request is only meaningful while running steadily
  always_comb begin
    cfg_ready = (state != PEND);
    running   = (state != IDLE);
    gate_d    = (state == RUN) && (div_act == ONE) && en;
  end

  // Next counter and ratio values
  always_comb begin
    cnt_nxt = '0;
    div_nxt = div_act;
    case (state)
      IDLE: if (take) div_nxt = cfg_div;
      RUN: begin
        cnt_nxt = wrap ? '0 : cnt + ONE;
        // A ratio arriving on the stopping wrap lands in IDLE, where it would load directly
        if (wrap && !en && take) div_nxt = cfg_div;
      end
      PEND: begin
        cnt_nxt = wrap ? '0 : cnt + ONE;
        if (wrap) div_nxt = pend_div;
      end
      default: cnt_nxt = '0;
    endcase
  end

  // Datapath registers; clk_p uses next-cycle values so it lines up with cnt
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      div_act  <= DIV_RST;
      pend_div <= '0;
      tick     <= 1'b0;
      cfg_err  <= 1'b0;
      clk_p    <= 1'b0;
    end else begin
      cnt     <= cnt_nxt;
      div_act <= div_nxt;
      if (state == RUN && take) pend_div <= cfg_div;
      tick    <= (state_nxt != IDLE) && (cnt_nxt == '0);
      cfg_err <= hs & cfg_zero;
      // N=1 is served by the gated source clock, so keep clk_p low to avoid a step at handover
      clk_p   <= (state_nxt != IDLE) && (div_nxt != ONE) && (cnt_nxt >= (div_nxt >> 1));
    end
  end

  // Clock-gate enable for N=1: transparent only while clk is low, so clkout never slivers
  always_latch begin
    if (rst)       gate_q <= 1'b0;
    else if (!clk) gate_q <= gate_d;
  end

`ifdef CLKDIV_CTRL_ODD50_EN
  logic clk_n;

  // Half-cycle delayed copy of clk_p; ANDing trims the high phase to exactly N/2 for odd N
  always_ff @(negedge clk or posedge rst) begin
    if (rst) clk_n <= 1'b0;
    else     clk_n <= clk_p;
  end

  assign wave = div_act[0] ? (clk_p & clk_n) : clk_p;
`else
  assign wave = clk_p;
`endif

  assign clkout = gate_q ? clk : wave;

endmodule

// File: tb/tb_clkdiv_ctrl.sv
module tb_clkdiv_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       cfg_valid;
  logic [7:0] cfg_div;
  logic       cfg_ready, cfg_err, running, tick, clkout;
  logic [7:0] div_act;

  int checks = 0;
  int passes = 0;
  int fails  = 0;
  string tag_s = "init";

  // Reference model: ratio in force, absolute start cycle of the current period, pending slot
  bit m_run, m_pend_vld, m_err, n1_open;
  int m_div, m_pend, m_start, ncyc;

  clkdiv_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .cfg_valid (cfg_valid),
    .cfg_div   (cfg_div),
    .cfg_ready (cfg_ready),
    .cfg_err   (cfg_err),
    .div_act   (div_act),
    .running   (running),
    .tick      (tick),
    .clkout    (clkout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_pend_vld = 0; m_err = 0; n1_open = 0;
    m_div = 5; m_pend = 0; m_start = 0; ncyc = 0;
  endtask

  // One source-clock edge of the model, applied to the inputs seen at that edge
  task automatic model_edge(input bit e, input bit v, input int d);
    bit acc, good;
    n1_open = m_run && !m_pend_vld && (m_div == 1) && e;
    acc   = v && !m_pend_vld;
    m_err = acc && (d == 0);
    good  = acc && (d != 0);
    ncyc++;
    if (!m_run) begin
      if (good) m_div = d;
      if (e) begin m_run = 1; m_start = ncyc; end
    end else if (ncyc - m_start == m_div) begin
      if (m_pend_vld) begin m_div = m_pend; m_pend_vld = 0; end
      if (!e) begin
        m_run = 0;
        if (good) m_div = d;
      end else begin
        m_start = ncyc;
        if (good) begin m_pend = d; m_pend_vld = 1; end
      end
    end else if (good) begin
      m_pend = d; m_pend_vld = 1;
    end
  endtask

  function automatic int pos();
    return ncyc - m_start;
  endfunction

  // Expected clkout level in the first (second=0) or second half of the current source cycle
  function automatic logic exp_clk(input bit second);
    if (!m_run) return 1'b0;
    if (m_div == 1) return second ? 1'b0 : n1_open;
`ifdef CLKDIV_CTRL_ODD50_EN
    return (2 * pos() + (second ? 1 : 0)) >= m_div;
`else
    return pos() >= (m_div / 2);
`endif
  endfunction

  task automatic check_all(input string ph);
    chk({ph, ".div_act"},   32'(div_act),   32'(m_div));
    chk({ph, ".cfg_ready"}, 32'(cfg_ready), 32'(!m_pend_vld));
    chk({ph, ".running"},   32'(running),   32'(m_run));
    chk({ph, ".tick"},      32'(tick),      32'(m_run && pos() == 0));
    chk({ph, ".cfg_err"},   32'(cfg_err),   32'(m_err));
    chk({ph, ".clkout_hi"}, 32'(clkout),    32'(exp_clk(1'b0)));
  endtask

  // Advance one source cycle, checking both halves; returns with clk low
  task automatic step();
    @(posedge clk);
    model_edge(en, cfg_valid, int'(cfg_div));
    #1;
    check_all(tag_s);
    @(negedge clk);
    #1;
    chk({tag_s, ".clkout_lo"}, 32'(clkout), 32'(exp_clk(1'b1)));
  endtask

  task automatic offer(input int d);
    cfg_valid = 1'b1;
    cfg_div   = 8'(d);
    step();
    cfg_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; cfg_valid = 1'b0; cfg_div = 8'd0;
    model_reset();
    #2;
    check_all("reset");
    @(negedge clk); #1;
    rst = 1'b0;

    // Default ratio 5 free-running
    tag_s = "n5";
    en = 1'b1;
    repeat (12) step();

    // Offer 4 when cnt = 1: current period still 5, then 4
    tag_s = "chg4";
    for (int i = 0; i < 10 && pos() != 1; i++) step();
    chk("chg4.wait", 32'(pos()), 32'd1);
    offer(4);
    chk("chg4.stall", 32'(cfg_ready), 32'd0);
    repeat (14) step();

    // Ratio 6, drop en at cnt = 2: period completes then IDLE
    tag_s = "stop6";
    offer(6);
    for (int i = 0; i < 20 && !(m_div == 6 && pos() == 2); i++) step();
    chk("stop6.wait", 32'(m_div == 6 && pos() == 2), 32'd1);
    en = 1'b0;
    repeat (10) step();

    // Zero ratio in IDLE and in RUN
    tag_s = "zero";
    offer(0);
    step();
    en = 1'b1;
    repeat (3) step();
    offer(0);
    repeat (8) step();

    // N = 1 then N = 3
    tag_s = "n1n3";
    offer(1);
    for (int i = 0; i < 20 && m_div != 1; i++) step();
    chk("n1.wait", 32'(m_div), 32'd1);
    repeat (4) step();
    offer(3);
    repeat (9) step();

    // Extremes: largest and smallest even ratio
    tag_s = "n255";
    offer(255);
    for (int i = 0; i < 20 && m_div != 255; i++) step();
    chk("n255.wait", 32'(m_div), 32'd255);
    repeat (260) step();
    tag_s = "n2";
    offer(2);
    repeat (270) begin
      if (m_div == 2) break;
      step();
    end
    chk("n2.wait", 32'(m_div), 32'd2);
    repeat (8) step();

    // Randomised offers, zero ratios and stops
    tag_s = "rand";
    repeat (250) begin
      en        = ($urandom_range(0, 7) != 0);
      cfg_valid = ($urandom_range(0, 3) == 0);
      cfg_div   = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom_range(1, 12));
      step();
    end
    cfg_valid = 1'b0;

    // Reset in the high phase with a ratio pending
    tag_s = "rst";
    en = 1'b1;
    for (int i = 0; i < 20 && m_pend_vld; i++) step();
    offer(6);
    for (int i = 0; i < 20 && !(m_div == 6 && pos() == 0); i++) step();
    offer(9);
    for (int i = 0; i < 10 && pos() < 3; i++) step();
    chk("rst.pending", 32'(m_pend_vld), 32'd1);
    chk("rst.before", 32'(clkout), 32'd1);
    rst = 1'b1;
    #1;
    chk("rst.async_clkout", 32'(clkout), 32'd0);
    model_reset();
    check_all("rst.hold");
    @(posedge clk); #1;
    check_all("rst.hold_edge");
    @(negedge clk); #1;
    rst = 1'b0;
    en  = 1'b0;
    tag_s = "post_rst";
    repeat (3) step();
    en = 1'b1;
    repeat (12) step();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
